// File: rtl/chan_scan_pkg.sv
// Shared types and constants for the channel-scan serializer.
package chan_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Width of a counter that holds values 0..dwell.
    function automatic int dwell_cnt_w(input int dwell);
        return $clog2(dwell + 1);
    endfunction

endpackage

// File: rtl/scan_onehot_dec.sv
// Binary channel index to one-hot select, forced to all-zero when not enabled.
module scan_onehot_dec #(
    parameter int NUM_CH = 4
) (
    input  logic [$clog2(NUM_CH)-1:0] idx,
    input  logic                      en,
    output logic [NUM_CH-1:0]         onehot
);

    always_comb begin
        // NOTE: assigning a default first means every path drives every bit, so no latch is inferred.
        onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            onehot[k] = en && (int'(idx) == k);
        end
    end

endmodule

// File: rtl/chan_scan_serializer.sv
// Snapshots NUM_CH parallel channels and serializes them with a per-channel dwell.
// Define CHAN_SCAN_MASK_EN to add ch_mask, which skips disabled channels.
module chan_scan_serializer
    import chan_scan_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 1,
    parameter int DWELL  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*CH_W-1:0]    din,
    input  logic                      start,
    input  logic                      continuous,
`ifdef CHAN_SCAN_MASK_EN
    input  logic [NUM_CH-1:0]         ch_mask,
`endif
    output logic                      busy,
    output logic [CH_W-1:0]           dout,
    output logic                      dout_valid,
    output logic [NUM_CH-1:0]         sel_onehot,
    output logic [$clog2(NUM_CH)-1:0] sel_idx,
    output logic                      frame_done
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = dwell_cnt_w(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t                   state, state_nxt;
    logic [NUM_CH*CH_W-1:0]   snap, snap_nxt;
    logic [NUM_CH-1:0]        mask, mask_nxt;
    logic [NUM_CH-1:0]        in_mask;
    logic [IDX_W-1:0]         idx_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [CH_W-1:0]          dout_nxt;
    logic [NUM_CH-1:0]        onehot_nxt;
    logic                     frame_done_nxt;

`ifdef CHAN_SCAN_MASK_EN
    assign in_mask = ch_mask;
`else
    assign in_mask = '1;
`endif

    function automatic logic [IDX_W-1:0] first_en(input logic [NUM_CH-1:0] m);
        first_en = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (m[k]) first_en = IDX_W'(k);
        end
    endfunction

    function automatic logic [IDX_W-1:0] last_en(input logic [NUM_CH-1:0] m);
        last_en = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (m[k]) last_en = IDX_W'(k);
        end
    endfunction

    // Lowest enabled channel above cur; only used when cur is not the last enabled one.
    function automatic logic [IDX_W-1:0] next_en(input logic [NUM_CH-1:0] m,
                                                 input logic [IDX_W-1:0]  cur);
        next_en = cur;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (m[k] && k > int'(cur)) next_en = IDX_W'(k);
        end
    endfunction

    always_comb begin
        state_nxt = state;
        snap_nxt  = snap;
        mask_nxt  = mask;
        idx_nxt   = sel_idx;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start && |in_mask) begin
                    state_nxt = SCAN;
                    snap_nxt  = din;
                    mask_nxt  = in_mask;
                    idx_nxt   = first_en(in_mask);
                    cnt_nxt   = '0;
                end
            end
            SCAN: begin
                if (cnt != CNT_LAST) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (sel_idx != last_en(mask)) begin
                    idx_nxt = next_en(mask, sel_idx);
                    cnt_nxt = '0;
                end else if (continuous && |in_mask) begin
                    // Back-to-back frame: fresh snapshot, no idle gap.
                    snap_nxt = din;
                    mask_nxt = in_mask;
                    idx_nxt  = first_en(in_mask);
                    cnt_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the next-state values.
    always_comb begin
        dout_nxt       = '0;
        frame_done_nxt = 1'b0;
        if (state_nxt == SCAN) begin
            dout_nxt       = snap_nxt[int'(idx_nxt)*CH_W +: CH_W];
            frame_done_nxt = (cnt_nxt == CNT_LAST) && (idx_nxt == last_en(mask_nxt));
        end
    end

    scan_onehot_dec #(.NUM_CH(NUM_CH)) u_dec (
        .idx    (idx_nxt),
        .en     (state_nxt == SCAN),
        .onehot (onehot_nxt)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: the snapshot is ordinary flops, not a memory array, so clearing it on reset is cheap.
            state      <= IDLE;
            snap       <= '0;
            mask       <= '0;
            cnt        <= '0;
            sel_idx    <= '0;
            busy       <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
            sel_onehot <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            snap       <= snap_nxt;
            mask       <= mask_nxt;
            cnt        <= cnt_nxt;
            sel_idx    <= idx_nxt;
            busy       <= (state_nxt == SCAN);
            dout_valid <= (state_nxt == SCAN);
            dout       <= dout_nxt;
            sel_onehot <= onehot_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_chan_scan_serializer.sv
// Scoreboard bench: two DUTs (DWELL=1 and DWELL=3) share stimulus; a frame-level model
// pushes expected cycles, and per-cycle monitors pop and compare.
`timescale 1ns/1ps
module tb_chan_scan_serializer;

    localparam int DW0 = 1;
    localparam int DW1 = 3;

    logic       clk = 1'b0;
    logic       rst, start, continuous;
    logic [3:0] din, mask;

    logic       busy0, dv0, fd0, busy1, dv1, fd1;
    logic [0:0] dout0, dout1;
    logic [3:0] oh0, oh1;
    logic [1:0] idx0, idx1;

    always #5 clk = ~clk;

    chan_scan_serializer #(.NUM_CH(4), .CH_W(1), .DWELL(DW0)) dut0 (
        .clk(clk), .rst(rst), .din(din), .start(start), .continuous(continuous),
`ifdef CHAN_SCAN_MASK_EN
        .ch_mask(mask),
`endif
        .busy(busy0), .dout(dout0), .dout_valid(dv0), .sel_onehot(oh0),
        .sel_idx(idx0), .frame_done(fd0)
    );

    chan_scan_serializer #(.NUM_CH(4), .CH_W(1), .DWELL(DW1)) dut1 (
        .clk(clk), .rst(rst), .din(din), .start(start), .continuous(continuous),
`ifdef CHAN_SCAN_MASK_EN
        .ch_mask(mask),
`endif
        .busy(busy1), .dout(dout1), .dout_valid(dv1), .sel_onehot(oh1),
        .sel_idx(idx1), .frame_done(fd1)
    );

    typedef struct {
        logic d;
        int   idx;
        logic done;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   left [2];
    int   total = 0;
    int   bad   = 0;
    logic rst_seen = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sb_size(input int inst);
        return (inst == 0) ? q0.size() : q1.size();
    endfunction

    task automatic sb_push(input int inst, input exp_t e);
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic sb_pop(input int inst, output exp_t e);
        if (inst == 0) e = q0.pop_front();
        else           e = q1.pop_front();
    endtask

    task automatic sb_flush(input int inst);
        if (inst == 0) q0.delete();
        else           q1.delete();
    endtask

    // One frame: every enabled channel in ascending order, DWELL cycles each.
    task automatic push_frame(input int inst, input logic [3:0] d, input logic [3:0] m,
                              output int len);
        int   dw;
        int   last;
        exp_t e;
        dw   = (inst == 0) ? DW0 : DW1;
        last = 0;
        len  = 0;
        for (int k = 0; k < 4; k++) if (m[k]) last = k;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                for (int r = 0; r < dw; r++) begin
                    e.d    = d[k];
                    e.idx  = k;
                    e.done = (k == last) && (r == dw - 1);
                    sb_push(inst, e);
                    len++;
                end
            end
        end
    endtask

    // Frame-level model: tracks cycles left in the current frame and decides what happens at its end.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int l;
            int len;
            l = left[i];
            if (rst) begin
                sb_flush(i);
                l = 0;
            end else if (l == 0) begin
                if (start && |mask) begin
                    push_frame(i, din, mask, len);
                    l = len;
                end
            end else begin
                l = l - 1;
                if (l == 0 && continuous && |mask) begin
                    push_frame(i, din, mask, len);
                    l = len;
                end
            end
            left[i] <= l;
        end
    end

    task automatic mon(input int inst, input logic b, input logic v, input logic d,
                       input logic [1:0] idx, input logic [3:0] oh, input logic fd);
        exp_t e;
        string p;
        p = $sformatf("dwell%0d", (inst == 0) ? DW0 : DW1);
        if (sb_size(inst) > 0) begin
            sb_pop(inst, e);
            check({p, "_valid"}, 32'(v), 32'd1);
            check({p, "_busy"}, 32'(b), 32'd1);
            check({p, "_dout"}, 32'(d), 32'(e.d));
            check({p, "_sel_idx"}, 32'(idx), 32'(e.idx));
            check({p, "_onehot"}, 32'(oh), 32'(1 << e.idx));
            check({p, "_frame_done"}, 32'(fd), 32'(e.done));
        end else begin
            check({p, "_idle_valid"}, 32'(v), 32'd0);
            check({p, "_idle_busy"}, 32'(b), 32'd0);
            check({p, "_idle_onehot"}, 32'(oh), 32'd0);
            check({p, "_idle_frame_done"}, 32'(fd), 32'd0);
            if (rst_seen) begin
                check({p, "_rst_dout"}, 32'(d), 32'd0);
                check({p, "_rst_sel_idx"}, 32'(idx), 32'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, busy0, dv0, dout0[0], idx0, oh0, fd0);
        mon(1, busy1, dv1, dout1[0], idx1, oh1, fd1);
        rst_seen = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((left[0] != 0 || left[1] != 0) && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(left[0] == 0 && left[1] == 0), 32'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; din = 4'h0; mask = 4'hF;
        left[0] = 0; left[1] = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single frame of 1010; din changes right after capture must not leak through.
        din = 4'b1010; start = 1'b1;
        tick();
        start = 1'b0; din = 4'b0101;
        wait_idle(100);

        // Continuous frames, din falls from F to 0 mid-frame.
        din = 4'hF; continuous = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        din = 4'h0;
        repeat (24) tick();
        continuous = 1'b0;
        wait_idle(100);

        // start while busy is ignored.
        din = 4'b0110; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; din = 4'b1001;
        tick();
        start = 1'b0;
        wait_idle(100);

        // Reset during cycle 2 of a frame aborts it.
        din = 4'hF; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();

`ifdef CHAN_SCAN_MASK_EN
        mask = 4'b1001; din = 4'b1001; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(100);
        mask = 4'b0000; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        mask = 4'hF; din = 4'hA; continuous = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mask = 4'b0000;
        wait_idle(100);
        continuous = 1'b0; mask = 4'hF;
        tick();
`endif

        for (int c = 0; c < 600; c++) begin
            din   = 4'($urandom);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) continuous = 1'($urandom);
            rst   = ($urandom_range(0, 59) == 0);
`ifdef CHAN_SCAN_MASK_EN
            mask  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
`endif
            tick();
        end
        start = 1'b0; rst = 1'b0; continuous = 1'b0;
        wait_idle(200);
        tick();
        check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chan_scan_serializer.md
CHAN_SCAN_SERIALIZER -- requirements
Module: chan_scan_serializer

Interface
REQ-001 Parameter NUM_CH, default 4, number of input channels; legal range 2..16.
REQ-002 Parameter CH_W, default 1, bits per channel.
REQ-003 Parameter DWELL, default 1, clock cycles spent on each channel; legal range 1..255.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 din  input  NUM_CH*CH_W  parallel channel data; channel k occupies bits [k*CH_W +: CH_W].
REQ-007 start  input  1  one-cycle request to begin a scan frame.
REQ-008 continuous  input  1  when 1, frames repeat back-to-back; when 0, a single frame runs.
REQ-009 busy  output  1  high while a frame is in progress.
REQ-010 dout  output  CH_W  serialized data of the current channel.
REQ-011 dout_valid  output  1  high on every cycle that dout carries channel data.
REQ-012 sel_onehot  output  NUM_CH  one-hot code of the current channel; all-zero when idle.
REQ-013 sel_idx  output  $clog2(NUM_CH)  binary index of the current channel.
REQ-014 frame_done  output  1  one-cycle pulse on the final dwell cycle of the last channel in a frame.

Function
REQ-015 The FSM SHALL have two states, IDLE and SCAN, and all outputs SHALL be registered.
REQ-016 In IDLE, start=1 at cycle t SHALL capture din into a snapshot register and enter SCAN at t+1 with sel_idx=0.
REQ-017 In SCAN, dout SHALL be taken from the snapshot, never directly from din, so din changes mid-frame have no effect.
REQ-018 Each channel SHALL be held for exactly DWELL cycles, after which sel_idx SHALL increment.
REQ-019 On the final dwell cycle of channel NUM_CH-1, frame_done SHALL pulse; at that point continuous is sampled.
REQ-020 If continuous=1 at frame end, din SHALL be re-snapshotted in the same cycle, sel_idx SHALL wrap to 0, and SCAN SHALL continue with no gap cycle.
REQ-021 If continuous=0 at frame end, the FSM SHALL return to IDLE on the next cycle.
REQ-022 Deasserting continuous mid-frame SHALL let the current frame complete.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 busy and dout_valid SHALL equal (state==SCAN); sel_onehot SHALL equal 1<<sel_idx in SCAN and 0 in IDLE.
REQ-025 The dwell counter SHALL be $clog2(DWELL+1) bits wide and reload to 0 on each channel change.

Reset
REQ-026 rst=1 SHALL force IDLE on the next edge, with busy=0, dout=0, dout_valid=0, sel_onehot=0, sel_idx=0, frame_done=0, and snapshot=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame without a frame_done pulse; rst has priority over start.

Configuration
REQ-028 Macro CHAN_SCAN_MASK_EN, when defined, SHALL add input ch_mask [NUM_CH], sampled together with din at each snapshot.
REQ-029 With CHAN_SCAN_MASK_EN defined:
- Channels whose mask bit is 0 SHALL be skipped with zero cycles spent on them.
- frame_done SHALL pulse on the last enabled channel.
- A start with ch_mask all-zero SHALL be ignored.
- A continuous re-snapshot with an all-zero mask SHALL return the FSM to IDLE.
REQ-030 Without CHAN_SCAN_MASK_EN, the port SHALL be absent and all channels SHALL be scanned.

Structure
REQ-031 Package chan_scan_pkg SHALL hold the state enum (IDLE, SCAN) and the DWELL width constant helper.
REQ-032 One sub-module, scan_onehot_dec, SHALL convert sel_idx to sel_onehot, parametrised by NUM_CH.

Verification
REQ-033 NUM_CH=4, CH_W=1, DWELL=1, din=4'b1010, start pulse, continuous=0:
- dout SHALL be 0,1,0,1 on 4 consecutive cycles.
- sel_onehot SHALL be 0001, 0010, 0100, 1000.
- frame_done SHALL pulse on the 4th cycle, then busy=0.
REQ-034 DWELL=3, continuous=1, din changed from 4'hF to 4'h0 mid-frame:
- Frame 1 SHALL output all 1s for 12 cycles.
- Frame 2 SHALL output 0s immediately with no gap cycle.
REQ-035 start pulsed at frame cycle 2 while busy -> frame timing SHALL be unchanged, and no restart SHALL occur.
REQ-036 rst asserted at cycle 2 of a frame -> all outputs SHALL be 0 on the next cycle, and no frame_done SHALL pulse.
REQ-037 With CHAN_SCAN_MASK_EN, ch_mask=4'b1001, din=4'b1001:
- Exactly 2 valid cycles SHALL occur, with sel_idx 0 then 3.
- frame_done SHALL pulse on sel_idx=3.
- ch_mask=0 with a start pulse SHALL leave busy=0.
